// File: rtl/hv_timing_gen.sv
// ---------------------------------------------------------------------------
// hv_timing_gen
//   Raster timing source: pixel/line counters, sync pulses, the display
//   window, line/frame strobes and a completed-frame counter. Every output is
//   a register loaded from the decode of the *next* counter values. That way
//   all outputs describe the same (hpos, vpos) in the same cycle.
//
//   Ports
//     clk          in   system clock
//     reset        in   synchronous, active-high reset (wins over ce)
//     ce           in   pixel clock enable; everything holds while 0
//     hpos[15:0]   out  pixel column, 0..H_TOTAL-1
//     vpos[15:0]   out  line, 0..V_TOTAL-1
//     hsync        out  horizontal sync, level HSYNC_ACTIVE during pulse
//     vsync        out  vertical sync, level VSYNC_ACTIVE during pulse
//     display_on   out  hpos < H_DISPLAY and vpos < V_DISPLAY
//     line_start   out  high while hpos == 0 (not for the reset-forced 0,0)
//     frame_start  out  high while (hpos,vpos) == (0,0) (not after reset)
//     frame_count  out  completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module hv_timing_gen #(
  parameter int H_DISPLAY    = 256,
  parameter int H_FRONT      = 7,
  parameter int H_SYNC       = 23,
  parameter int H_BACK       = 23,
  parameter int V_DISPLAY    = 240,
  parameter int V_BOTTOM     = 14,
  parameter int V_SYNC       = 3,
  parameter int V_TOP        = 5,
  parameter bit HSYNC_ACTIVE = 1'b1,
  parameter bit VSYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic [15:0] hpos,
  output logic [15:0] vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS      = 16'(H_DISPLAY);
  localparam logic [15:0] V_VIS      = 16'(V_DISPLAY);
  localparam logic [15:0] HS_FIRST   = 16'(H_DISPLAY + H_FRONT);
  localparam logic [15:0] HS_LAST    = 16'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST   = 16'(V_DISPLAY + V_BOTTOM);
  localparam logic [15:0] VS_LAST    = 16'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [15:0] h_nxt;
  logic [15:0] v_nxt;
  logic        frame_wrap;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        disp_nxt;

  // Next counter values for a ce=1 cycle. ">=" rather than "==" keeps the
  // counters bounded even if they ever held an out-of-range value.
  always_comb begin
    h_nxt      = hpos + 16'd1;
    v_nxt      = vpos;
    frame_wrap = 1'b0;
    if (hpos >= H_LAST) begin
      h_nxt = 16'd0;
      if (vpos >= V_LAST) begin
        v_nxt      = 16'd0;
        frame_wrap = 1'b1;
      end else begin
        v_nxt = vpos + 16'd1;
      end
    end
  end

  // Output decode of the next position; vsync depends only on the line, so
  // it naturally changes only when h_nxt returns to 0.
  always_comb begin
    hs_nxt   = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_nxt   = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    disp_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= 16'd0;
      vpos        <= 16'd0;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else if (ce) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= hs_nxt ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync       <= vs_nxt ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      display_on  <= disp_nxt;
      line_start  <= (h_nxt == 16'd0);
      frame_start <= frame_wrap;
      frame_count <= frame_count + {7'd0, frame_wrap};
    end
  end

endmodule
